// File: rtl/line_buffer_window.sv
// Circular line buffer producing KERNEL_W-wide pixel windows.
// One instance per kernel row; skips to the next row at end of line.
module line_buffer_window #(
  parameter int DATA_W   = 8,
  parameter int LINE_W   = 512,
  parameter int KERNEL_W = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_en,
  output logic                         full,
  input  logic                         rd_en,
  output logic                         win_ready,
  output logic [KERNEL_W*DATA_W-1:0]   win_data,
  output logic                         win_valid,
  output logic                         row_end,
  output logic [$clog2(LINE_W+1)-1:0]  count,
  output logic                         overflow
);

  localparam int PTR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int CNT_W = $clog2(LINE_W+1);
  localparam int COL_N = LINE_W - KERNEL_W;
  localparam int COL_W = (COL_N > 0) ? $clog2(COL_N+1) : 1;

  localparam logic [PTR_W:0]   LINE_P   = (PTR_W+1)'(LINE_W);
  localparam logic [PTR_W:0]   KERN_P   = (PTR_W+1)'(KERNEL_W);
  localparam logic [CNT_W-1:0] LINE_C   = CNT_W'(LINE_W);
  localparam logic [CNT_W-1:0] KERN_C   = CNT_W'(KERNEL_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COL_N);

  logic [DATA_W-1:0]          mem [LINE_W];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [COL_W-1:0]           rd_col;
  logic                       wr_acc;
  logic                       rd_acc;
  logic                       last_col;
  logic [CNT_W-1:0]           consume;
  logic [PTR_W:0]             rd_step;
  logic [KERNEL_W*DATA_W-1:0] win_next;

  // Modular add; operands never exceed one full lap, so one subtract wraps.
  function automatic logic [PTR_W-1:0] wrap_add(
    input logic [PTR_W-1:0] p,
    input logic [PTR_W:0]   d
  );
    logic [PTR_W:0] s;
    s = {1'b0, p} + d;
    if (s >= LINE_P) s = s - LINE_P;
    return s[PTR_W-1:0];
  endfunction

  assign full      = (count == LINE_C);
  assign win_ready = (count >= KERN_C);
  assign wr_acc    = wr_en && !full;
  assign rd_acc    = rd_en && win_ready;
  assign last_col  = (rd_col == LAST_COL);
  assign consume   = last_col ? KERN_C : CNT_W'(1);
  assign rd_step   = last_col ? KERN_P : (PTR_W+1)'(1);

  // Gather the window at rd_ptr, oldest pixel into the MSBs
  always_comb begin
    win_next = '0;
    for (int i = 0; i < KERNEL_W; i++) begin
      win_next[(KERNEL_W-1-i)*DATA_W +: DATA_W] =
        mem[wrap_add(rd_ptr, (PTR_W+1)'(i))];
    end
  end

  // Pixel storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Write pointer advances on every accepted write
  always_ff @(posedge clk) begin
    if (reset) wr_ptr <= '0;
    else if (wr_acc) wr_ptr <= wrap_add(wr_ptr, (PTR_W+1)'(1));
  end

  // Read pointer steps by one, or jumps past the row tail at row end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      rd_col <= '0;
    end else if (rd_acc) begin
      rd_ptr <= wrap_add(rd_ptr, rd_step);
      rd_col <= last_col ? '0 : rd_col + COL_W'(1);
    end
  end

  // Occupancy: add accepted write, remove consumed pixels
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else count <= count + CNT_W'(wr_acc)
                        - (rd_acc ? consume : '0);
  end

  // Registered window output, one cycle after an accepted read
  always_ff @(posedge clk) begin
    if (reset) begin
      win_data  <= '0;
      win_valid <= 1'b0;
      row_end   <= 1'b0;
    end else begin
      win_valid <= rd_acc;
      row_end   <= rd_acc && last_col;
      if (rd_acc) win_data <= win_next;
    end
  end

  // Sticky flag for writes attempted while full
  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

endmodule

// File: doc/line_buffer_window.md
Name: line_buffer_window

Overview:
- Parametrised circular line buffer for the sliding-window convolution datapath. Generalises the fixed 8-bit / 512-deep / 3-tap buffer to any pixel width, line length and kernel width.
- Adds occupancy tracking, full/window-ready flow control, overflow detection, a registered window output and automatic end-of-row pointer skip.
- Sits between the pixel input stream and the KxK multiply-accumulate stage; one instance per kernel row.

Parameters:
- DATA_W, 8, bits per pixel
- LINE_W, 512, pixels per image line = buffer depth; any integer ≥ KERNEL_W, not necessarily a power of 2
- KERNEL_W, 3, window width in pixels; 1 ≤ KERNEL_W ≤ LINE_W

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_data  in  DATA_W  pixel to write
- wr_en  in  1  write request
- full  out  1  count == LINE_W
- rd_en  in  1  window read request
- win_ready  out  1  count ≥ KERNEL_W
- win_data  out  KERNEL_W*DATA_W  registered window; pixel at read pointer in MSBs, pixel at rd_ptr+KERNEL_W-1 in LSBs
- win_valid  out  1  win_data valid this cycle
- row_end  out  1  aligned with win_valid; this window is the last of its row
- count  out  $clog2(LINE_W+1)  stored pixel count
- overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset values (sync, active-high): wr_ptr=0, rd_ptr=0, rd_col=0, count=0, win_data=0, win_valid=0, row_end=0, overflow=0. Memory contents are not reset.
- Write is accepted when wr_en && !full: mem[wr_ptr]<=wr_data; wr_ptr increments and wraps from LINE_W-1 to 0 (explicit compare, not natural overflow).
- Write while full: data dropped, pointers and count unchanged, overflow<=1 until reset.
- Read is accepted when rd_en && win_ready.
  - Window taken from mem[(rd_ptr+i) mod LINE_W], i=0..KERNEL_W-1; wrap across the end of memory is required.
  - Next cycle: win_valid=1, win_data holds the window. Latency is 1 cycle from accepted rd_en.
- rd_en while !win_ready: ignored, win_valid=0 next cycle, no state change. Not an error.
- Column tracking: rd_col counts accepted reads within a row, 0..LINE_W-KERNEL_W.
  - Normal read (rd_col < LINE_W-KERNEL_W): rd_ptr+=1 (mod LINE_W); consume=1; rd_col+=1.
  - Last read of row (rd_col == LINE_W-KERNEL_W): rd_ptr+=KERNEL_W (mod LINE_W); consume=KERNEL_W; rd_col<=0; row_end=1 alongside win_valid.
  - Result: the next row's first window starts at that row's pixel 0.
- Count update: count_next = count + wr_acc - (rd_acc ? consume : 0).
  - Simultaneous accepted write and read in the same cycle are legal.
  - full and win_ready are evaluated on the pre-update count; a write is not accepted into a slot being freed in the same cycle.
  - Writes to the slot at wr_ptr never collide with window addresses, since count < LINE_W is required for a write.
- full and win_ready are combinational from count; count is a register.
- KERNEL_W==1: every read consumes 1; row_end fires every LINE_W reads.
- Reset mid-operation: all pointers and flags return to reset values next cycle; an in-flight win_valid is cleared.
- Window read uses async read of the memory array; win_data is registered.

Test Plan (DATA_W=8, LINE_W=8, KERNEL_W=3):
1. Reset, write 0x10,0x11,0x12 -> win_ready rises when count=3; rd_en -> next cycle win_valid=1, win_data=0x101112, count=2.
2. Write 8 pixels 0x00..0x07 without reads -> full=1, count=8; 9th write 0xFF -> dropped, count=8, overflow=1 and stays 1 until reset.
3. Fill 0x00..0x07, issue 6 back-to-back reads -> windows 0x000102..0x050607; row_end=1 only on the 6th; count=0 afterwards; rd_ptr=0.
4. Stream continuously with wr_en and rd_en asserted together across 3 rows -> rd_ptr/wr_ptr wrap 7->0; a window spanning addresses 7,0,1 returns the correct pixels; count never exceeds 8; no overflow.
5. rd_en with count=2 -> win_valid stays 0, count=2; rd_en with count=3 plus simultaneous write -> count stays 3.
6. Assert reset mid-stream with win_valid pending -> next cycle win_valid=0, count=0, full=0, overflow=0; first window after refill starts from new data.
